// File: rtl/pri_codec_pkg.sv
// rtl/pri_codec_pkg.sv - shared widths and grant FSM state type for the priority codec blocks
package pri_codec_pkg;

  localparam int IDX_W     = 3;
  localparam int ONE_HOT_W = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } grant_state_t;

endpackage

// File: rtl/dec_3to8.sv
// rtl/dec_3to8.sv - combinational 3-to-8 one-hot decoder with enable
module dec_3to8
  import pri_codec_pkg::*;
(
  input  logic                 en,
  input  logic [IDX_W-1:0]     idx,
  output logic [ONE_HOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/pri_grant_decoder.sv
// rtl/pri_grant_decoder.sv - timed one-hot grant strobe from a 3-bit index with hold and guard gap
module pri_grant_decoder
  import pri_codec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IDX_W-1:0]     in_idx,
  output logic                 in_ready,
  output logic [ONE_HOT_W-1:0] out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  grant_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ONE_HOT_W-1:0]  out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic [ONE_HOT_W-1:0]  dec_onehot;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  dec_3to8 u_dec (
    .en     (accept),
    .idx    (in_idx),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter only decrements when nonzero, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = dec_onehot;
        if (accept) begin
          cnt_d   = HOLD_LOAD;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          out_d  = '0;
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        out_d = '0;
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        out_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/pri_grant_decoder.md
# pri_grant_decoder

Sequential 3-to-8 grant decoder: the inverse of the 8x3 priority encoder. It accepts a 3-bit index with a valid/ready handshake and drives the corresponding one-hot line of `out` for a programmable number of cycles. It then releases and enforces a guard gap before accepting the next request. It sits downstream of `pri_encoder` (or any index source) and converts a winning index back into a timed one-hot grant/select strobe.

## Interface
- `HOLD_CYCLES`, 4: cycles the one-hot grant is held; legal range 1..255.
- `GAP_CYCLES`, 1: idle cycles after release before `in_ready` rises; legal range 0..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: request present.
- `in_idx` input 3: index to decode; bit `in_idx` of `out` is asserted.
- `in_ready` output 1: block can accept a request (combinational from state).
- `out` output 8: registered one-hot grant, or all zeros.
- `busy` output 1: registered; high in HOLD and GAP.
- `done` output 1: registered single-cycle pulse on release.

## Operation
- States: IDLE, HOLD, GAP.
- IDLE:
  - `in_ready`=1, `out`=0.
  - Handshake is `in_valid && in_ready` at a rising edge. On handshake: `out` <= 1<<`in_idx`, counter <= HOLD_CYCLES-1, go to HOLD.
  - `in_valid`=0 leaves `out`=0. This mirrors the encoder's valid=0 case.
- HOLD:
  - `in_ready`=0, `out` stable, `in_idx`/`in_valid` ignored.
  - Counter decrements each edge. When the counter is 0 at an edge: `out` <= 0 and `done` <= 1.
  - Next state is GAP with counter <= GAP_CYCLES-1 if GAP_CYCLES>0, otherwise IDLE.
- GAP:
  - `in_ready`=0, `out`=0.
  - Counter decrements. At 0, go to IDLE.
- `done` is high for exactly one cycle per grant, coincident with the first zero cycle of `out`.
- Invariants:
  - `out` never has more than one bit set.
  - At least one all-zero cycle separates consecutive grants, even with GAP_CYCLES=0.
- Counter is 8 bits. The compare is against zero, so there is no wrap: a decrement never occurs from zero.
- Reset values: `out`=0, `busy`=0, `done`=0, state IDLE, counter 0. `in_ready` reads 1 while `rst_n` is low, but no capture occurs.
- Reset asserted mid-HOLD or mid-GAP: `out` clears immediately (asynchronous) and there is no `done` pulse. After release the block is in IDLE.

## Timing
- Handshake at edge k gives `out` one-hot during cycles k+1 .. k+HOLD_CYCLES (one-cycle latency).
- `out`=0 and `done`=1 after edge k+HOLD_CYCLES.
- `in_ready` is high again after edge k+HOLD_CYCLES+GAP_CYCLES.
- Maximum acceptance rate is one request per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Back-to-back with GAP_CYCLES=0: the next handshake can occur at edge k+HOLD_CYCLES+1, and its grant appears the following cycle.
- `in_valid` held high while `in_ready`=0 is not consumed. It is accepted on the first IDLE edge.

## Structure
- Shared package `pri_codec_pkg`:
  - `IDX_W`=3 and `ONE_HOT_W`=8, also consumed by `pri_encoder`.
  - Enum `grant_state_t` {IDLE, HOLD, GAP}.
- Sub-module `dec_3to8`: a purely combinational 3-to-8 one-hot decoder with an enable. It is instantiated once to feed the `out` register. The FSM and counter live in the top.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Expect `out`=8'b0, `busy`=0, `done`=0, `in_ready`=1.
- Single grant, HOLD=4, GAP=1: `in_idx`=3'd5, one-cycle valid. Expect:
  - `out`=8'b00100000 for exactly 4 cycles;
  - then `done` for 1 cycle;
  - `in_ready` low 1 further cycle.
- Sweep all eight `in_idx` values 0..7 with `in_valid` held high. Each `out` equals 1<<idx, with exactly one bit set. Feeding `out` into `pri_encoder` returns valid=1 and the same idx.
- Ignored input: change `in_idx` from 2 to 6 mid-HOLD. `out` stays 8'b00000100, and 6 is accepted only after `in_ready` returns.
- GAP=0 back-to-back: idx 1 then idx 7. Expect exactly one zero cycle between 8'b00000010 and 8'b10000000, with `done` in that cycle.
- Reset mid-HOLD (idx 4, cycle 2 of 4): `out` drops to 0 asynchronously, with no `done` pulse. After release the next request is accepted normally.
